axi_mem_responder: RTL

AXI4 slave (responder) memory model answering the 32-bit AXI4 master port of memory_controller, standing in for the DDR2 MIG core in simulation and in MIG-less FPGA builds. Word-addressed on-chip RAM; independent write (AW/W/B) and read (AR/R) FSMs; INCR bursts up to 256 beats; one outstanding transaction per direction.

---
 rtl/axi_mem_responder.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model: word-addressed on-chip RAM behind independent
// write (AW/W/B) and read (AR/R) state machines. INCR bursts of up to 256
// beats, one outstanding transaction per direction, per-beat range check.
//
// Write FSM
//   state  | meaning
//   W_IDLE | awready high, waiting for a write address
//   W_DATA | wready high, writing one strobed word per W handshake
//   W_RESP | bvalid high, holding bid/bresp until bready
//
// Read FSM
//   state   | meaning
//   R_IDLE  | arready high, waiting for a read address
//   R_FETCH | one cycle, registering the first word of the burst
//   R_DATA  | rvalid high, next word prefetched on every R handshake
module axi_mem_responder #(
    parameter int    DEPTH     = 4096,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  axi_awid,
    input  logic [31:0] axi_awaddr,
    input  logic [7:0]  axi_awlen,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wlast,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic [3:0]  axi_bid,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    input  logic [3:0]  axi_arid,
    input  logic [31:0] axi_araddr,
    input  logic [7:0]  axi_arlen,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    output logic [3:0]  axi_rid,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rlast,
    output logic        axi_rvalid,
    input  logic        axi_rready
);

    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    logic [31:0] mem [DEPTH];

    // Byte lane offset is ignored: every beat is a full word, INCR by 4 bytes
    logic unused_addr_bits;
    assign unused_addr_bits = ^{axi_awaddr[1:0], axi_araddr[1:0]};

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    w_state_t           w_state;
    w_state_t           w_next;
    logic [3:0]         w_id;
    logic [29:0]        w_waddr;
    logic [7:0]         w_len;
    logic [7:0]         w_cnt;
    logic               w_slverr;
    logic               w_decerr;
    logic               aw_hs;
    logic               w_hs;
    logic               w_oor;
    logic               w_final;
    logic               w_last_err;
    logic [ADDR_W-1:0]  w_idx;

    assign aw_hs      = axi_awvalid & axi_awready;
    assign w_hs       = axi_wvalid & axi_wready;
    assign w_oor      = (w_waddr >> ADDR_W) != 30'd0;
    assign w_final    = (w_cnt == w_len);
    assign w_last_err = (axi_wlast != w_final);
    assign w_idx      = w_waddr[ADDR_W-1:0];

    // Write FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    // Write FSM next state and handshake outputs decoded from state
    always_comb begin
        w_next      = w_state;
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                axi_awready = 1'b1;
                if (axi_awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                axi_wready = 1'b1;
                if (axi_wvalid && w_final) w_next = W_RESP;
            end
            W_RESP: begin
                axi_bvalid = 1'b1;
                if (axi_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Write burst tracking; error flags are sticky and folded into bresp on the last beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_id      <= '0;
            w_waddr   <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            w_slverr  <= 1'b0;
            w_decerr  <= 1'b0;
            axi_bid   <= '0;
            axi_bresp <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                w_id     <= axi_awid;
                w_waddr  <= axi_awaddr[31:2];
                w_len    <= axi_awlen;
                w_cnt    <= '0;
                w_slverr <= 1'b0;
                w_decerr <= 1'b0;
            end
            if (w_hs) begin
                w_waddr <= w_waddr + 30'd1;
                w_cnt   <= w_cnt + 8'd1;
                if (w_oor)      w_decerr <= 1'b1;
                if (w_last_err) w_slverr <= 1'b1;
                if (w_final) begin
                    axi_bid <= w_id;
                    if (w_decerr || w_oor) begin
                        axi_bresp <= RESP_DECERR;
                    end else if (w_slverr || w_last_err) begin
                        axi_bresp <= RESP_SLVERR;
                    end else begin
                        axi_bresp <= RESP_OKAY;
                    end
                end
            end
        end
    end

    // RAM write port: strobed byte lanes, out-of-range beats are dropped
    always_ff @(posedge clk) begin
        if (w_hs && !w_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (axi_wstrb[b]) mem[w_idx][8*b +: 8] <= axi_wdata[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    r_state_t           r_state;
    r_state_t           r_next;
    logic [3:0]         r_id;
    logic [29:0]        r_waddr;
    logic [7:0]         r_len;
    logic [7:0]         r_cnt;
    logic               ar_hs;
    logic               r_hs;
    logic               r_fetch;
    logic               r_oor;
    logic [ADDR_W-1:0]  r_idx;

    assign ar_hs   = axi_arvalid & axi_arready;
    assign r_hs    = axi_rvalid & axi_rready;
    // r_waddr/r_cnt always point at the beat to be fetched next
    assign r_fetch = (r_state == R_FETCH) | (r_hs & ~axi_rlast);
    assign r_oor   = (r_waddr >> ADDR_W) != 30'd0;
    assign r_idx   = r_waddr[ADDR_W-1:0];

    // Read FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    // Read FSM next state and handshake outputs decoded from state
    always_comb begin
        r_next      = r_state;
        axi_arready = 1'b0;
        axi_rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                axi_arready = 1'b1;
                if (axi_arvalid) r_next = R_FETCH;
            end
            R_FETCH: begin
                r_next = R_DATA;
            end
            R_DATA: begin
                axi_rvalid = 1'b1;
                if (axi_rready && axi_rlast) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read burst tracking and registered R beat; outputs only change on a fetch,
    // so they hold while the master stalls. RAM read happens before the write
    // lands, giving read-first behaviour on a same-word collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_id      <= '0;
            r_waddr   <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            axi_rid   <= '0;
            axi_rdata <= '0;
            axi_rresp <= RESP_OKAY;
            axi_rlast <= 1'b0;
        end else begin
            if (ar_hs) begin
                r_id    <= axi_arid;
                r_waddr <= axi_araddr[31:2];
                r_len   <= axi_arlen;
                r_cnt   <= '0;
            end
            if (r_fetch) begin
                axi_rid   <= r_id;
                axi_rdata <= r_oor ? 32'd0 : mem[r_idx];
                axi_rresp <= r_oor ? RESP_DECERR : RESP_OKAY;
                axi_rlast <= (r_cnt == r_len);
                r_waddr   <= r_waddr + 30'd1;
                r_cnt     <= r_cnt + 8'd1;
            end else if (r_hs) begin
                axi_rlast <= 1'b0;
            end
        end
    end

endmodule
